// File: rtl/axis_bram_frame_writer_pkg.sv
// Shared types and helpers for the AXI4-Stream to BRAM frame writer.
package axis_bram_frame_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Beat counter needs one extra bit so a full-BRAM frame can report 2^addr_width.
    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/axis_bram_frame_writer.sv
// Captures one frame of AXI4-Stream beats into BRAM port A at addresses 0..cfg_data.
// Optional ring-buffer mode: define AXIS_BRAM_FRAME_WRITER_WRAP_EN.
module axis_bram_frame_writer
    import axis_bram_frame_writer_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned BRAM_DATA_WIDTH  = 32,
    parameter int unsigned BRAM_ADDR_WIDTH  = 14
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
    input  logic                        cfg_start,
    output logic [BRAM_ADDR_WIDTH:0]    sts_data,
    output logic                        sts_busy,
    output logic                        sts_done,
    output logic                        sts_tlast_err,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]  bram_porta_wrdata,
    output logic                        bram_porta_we
);

    localparam int unsigned CW = count_width(BRAM_ADDR_WIDTH);

    state_t                     state, state_nxt;
    logic [CW-1:0]              count, count_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] last_reg, last_nxt;
    logic                       err, err_nxt;
    logic                       start_d;
    logic                       start_edge;
    logic                       accept;
    logic                       final_beat;
    logic                       unused_inputs;

    assign start_edge = cfg_start & ~start_d;
    assign accept     = s_axis_tvalid & s_axis_tready;
    assign final_beat = (count == CW'(last_reg));

    // Start-edge history tracks cfg_start even in reset so a level held across reset is not an edge.
    always_ff @(posedge aclk) begin
        start_d <= cfg_start;
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            count    <= '0;
            last_reg <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            last_reg <= last_nxt;
            err      <= err_nxt;
        end
    end

    // Next-state, beat counting and framing check.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        last_nxt  = last_reg;
        err_nxt   = err;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_nxt = WRITE;
                    last_nxt  = cfg_data;
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                end
            end
            WRITE: begin
`ifdef AXIS_BRAM_FRAME_WRITER_WRAP_EN
                if (!cfg_start) begin
                    state_nxt = DONE;
                end else if (accept) begin
                    count_nxt = final_beat ? '0 : count + CW'(1);
                end
`else
                if (accept) begin
                    count_nxt = count + CW'(1);
                    if (final_beat) begin
                        state_nxt = DONE;
                    end
                    if (s_axis_tlast != final_beat) begin
                        err_nxt = 1'b1;
                    end
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stream handshake: ready only while writing (and, in ring mode, while armed).
`ifdef AXIS_BRAM_FRAME_WRITER_WRAP_EN
    assign s_axis_tready = (state == WRITE) & cfg_start & aresetn;
`else
    assign s_axis_tready = (state == WRITE) & aresetn;
`endif

    // Tdata bits above the BRAM width and tlast (ring mode) are intentionally dropped.
    assign unused_inputs = ^{s_axis_tdata, s_axis_tlast};

    assign sts_data      = count;
    assign sts_busy      = (state == WRITE);
    assign sts_done      = (state == DONE);
    assign sts_tlast_err = err;

    assign bram_porta_clk    = aclk;
    assign bram_porta_rst    = ~aresetn;
    assign bram_porta_addr   = count[BRAM_ADDR_WIDTH-1:0];
    assign bram_porta_wrdata = s_axis_tdata[BRAM_DATA_WIDTH-1:0];
    assign bram_porta_we     = accept;

endmodule
